if_fetch: RTL

Instruction-fetch front end of the siiCpu pipeline. It owns the program counter, drives the synchronous instruction-memory address, and produces the `pc` and `predt_br_taken` pair consumed by the IF/ID pipeline register. It honours the hazard unit's `if_stall`/`if_flush` and predicts taken branches with a direct-mapped branch target buffer (BTB) that is trained from EX.

---
 rtl/if_fetch_pkg.sv | 17 +
 rtl/if_btb.sv | 82 ++++++++
 rtl/if_fetch.sv | 87 ++++++++
 3 files changed

// File: rtl/if_fetch_pkg.sv
// Shared constants for the instruction-fetch front end.
//   PC_WIDTH   : program counter / address width
//   WORD_WIDTH : instruction word width
//   RESET_PC   : default PC after reset
//   CTR_*      : 2-bit saturating branch counter encodings
package if_fetch_pkg;

    localparam int unsigned PC_WIDTH   = 32;
    localparam int unsigned WORD_WIDTH = 32;
    localparam logic [31:0] RESET_PC   = 32'h0000_0000;

    localparam logic [1:0] CTR_SNT = 2'd0;  // strong not-taken
    localparam logic [1:0] CTR_WNT = 2'd1;  // weak not-taken
    localparam logic [1:0] CTR_WT  = 2'd2;  // weak taken
    localparam logic [1:0] CTR_ST  = 2'd3;  // strong taken

endpackage

// File: rtl/if_btb.sv
// Direct-mapped branch target buffer.
//   clk, rst_n          : clock, asynchronous active-low reset
//   cpu_en              : update enable (state frozen when low)
//   lkp_pc              : combinational lookup address
//   lkp_hit/taken/target: lookup result (taken = hit && ctr[1])
//   upd_valid/pc/taken/target : registered training port from EX
module if_btb #(
    parameter int unsigned PC_WIDTH    = 32,
    parameter int unsigned BTB_ENTRIES = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cpu_en,
    input  logic [PC_WIDTH-1:0] lkp_pc,
    output logic                lkp_hit,
    output logic                lkp_taken,
    output logic [PC_WIDTH-1:0] lkp_target,
    input  logic                upd_valid,
    input  logic [PC_WIDTH-1:0] upd_pc,
    input  logic                upd_taken,
    input  logic [PC_WIDTH-1:0] upd_target
);
    import if_fetch_pkg::*;

    localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_W = PC_WIDTH - IDX_W - 2;

    logic                valid_q  [BTB_ENTRIES];
    logic [TAG_W-1:0]    tag_q    [BTB_ENTRIES];
    logic [PC_WIDTH-3:0] target_q [BTB_ENTRIES];  // word address, low two bits implied 0
    logic [1:0]          ctr_q    [BTB_ENTRIES];

    logic [IDX_W-1:0] lkp_idx;
    logic [TAG_W-1:0] lkp_tag;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;

    assign lkp_idx = lkp_pc[IDX_W+1:2];
    assign lkp_tag = lkp_pc[PC_WIDTH-1:IDX_W+2];
    assign upd_idx = upd_pc[IDX_W+1:2];
    assign upd_tag = upd_pc[PC_WIDTH-1:IDX_W+2];

    // Lookup reads the registered arrays, so a same-cycle update is seen next cycle.
    assign lkp_hit    = valid_q[lkp_idx] && (tag_q[lkp_idx] == lkp_tag);
    assign lkp_taken  = lkp_hit && ctr_q[lkp_idx][1];
    assign lkp_target = {target_q[lkp_idx], 2'b00};

    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(BTB_ENTRIES); i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_SNT;
            end
        end else if (upd_valid && cpu_en) begin
            if (upd_hit) begin
                if (upd_taken) begin
                    target_q[upd_idx] <= upd_target[PC_WIDTH-1:2];
                    if (ctr_q[upd_idx] != CTR_ST) begin
                        ctr_q[upd_idx] <= ctr_q[upd_idx] + 2'd1;
                    end
                end else if (ctr_q[upd_idx] != CTR_SNT) begin
                    ctr_q[upd_idx] <= ctr_q[upd_idx] - 2'd1;
                end
            end else if (upd_taken) begin
                // Allocate weak-taken, evicting whatever aliased here.
                valid_q[upd_idx]  <= 1'b1;
                tag_q[upd_idx]    <= upd_tag;
                target_q[upd_idx] <= upd_target[PC_WIDTH-1:2];
                ctr_q[upd_idx]    <= CTR_WT;
            end
        end
    end

    logic unused_bits;
    assign unused_bits = ^{lkp_pc[1:0], upd_pc[1:0], upd_target[1:0], CTR_WNT};

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch front end: PC register, next-PC mux and BTB prediction.
//   clk, rst_n       : clock, asynchronous active-low reset
//   cpu_en           : global run enable; all state frozen when low
//   if_stall         : hold PC
//   if_flush         : load redirect_pc (overrides stall)
//   redirect_pc      : corrected next PC
//   upd_*            : BTB training from EX
//   imem_en          : instruction memory read enable (= cpu_en)
//   imem_addr        : instruction memory address (= pc)
//   pc               : current fetch PC
//   predt_br_taken   : BTB prediction for pc
module if_fetch #(
    parameter int unsigned          PC_WIDTH    = if_fetch_pkg::PC_WIDTH,
    parameter logic [PC_WIDTH-1:0]  RESET_PC    = if_fetch_pkg::RESET_PC,
    parameter int unsigned          BTB_ENTRIES = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cpu_en,
    input  logic                if_stall,
    input  logic                if_flush,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    input  logic                upd_valid,
    input  logic [PC_WIDTH-1:0] upd_pc,
    input  logic                upd_taken,
    input  logic [PC_WIDTH-1:0] upd_target,
    output logic                imem_en,
    output logic [PC_WIDTH-1:0] imem_addr,
    output logic [PC_WIDTH-1:0] pc,
    output logic                predt_br_taken
);
    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] pc_d;
    logic [PC_WIDTH-1:0] pc_plus4;
    logic                btb_hit;
    logic                btb_taken;
    logic [PC_WIDTH-1:0] btb_target;

    if_btb #(
        .PC_WIDTH    (PC_WIDTH),
        .BTB_ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_en     (cpu_en),
        .lkp_pc     (pc_q),
        .lkp_hit    (btb_hit),
        .lkp_taken  (btb_taken),
        .lkp_target (btb_target),
        .upd_valid  (upd_valid),
        .upd_pc     (upd_pc),
        .upd_taken  (upd_taken),
        .upd_target (upd_target)
    );

    assign pc_plus4 = pc_q + {{(PC_WIDTH-3){1'b0}}, 3'd4};

    always_comb begin
        pc_d = pc_q;
        if (if_flush) begin
            pc_d = {redirect_pc[PC_WIDTH-1:2], 2'b00};
        end else if (if_stall) begin
            pc_d = pc_q;
        end else if (btb_taken) begin
            pc_d = btb_target;
        end else begin
            pc_d = pc_plus4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= {RESET_PC[PC_WIDTH-1:2], 2'b00};
        end else if (cpu_en) begin
            pc_q <= pc_d;
        end
    end

    assign pc             = pc_q;
    assign imem_addr      = pc_q;
    assign imem_en        = cpu_en;
    assign predt_br_taken = btb_taken;

    logic unused_bits;
    assign unused_bits = ^{redirect_pc[1:0], btb_hit};

endmodule
